// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between an ADC controller (master) and the ADC or its
// responder model (slave).
interface adc_spi_responder_if;
  logic adc_cs;
  logic adc_clk;
  logic adc_mosi;
  logic adc_miso;

  modport master (
    output adc_cs,
    output adc_clk,
    output adc_mosi,
    input  adc_miso
  );

  modport slave (
    input  adc_cs,
    input  adc_clk,
    input  adc_mosi,
    output adc_miso
  );
endinterface

// File: rtl/adc_spi_responder.sv
// SPI responder model of an 8-channel 10-bit ADC with MCP3008-style framing.
// It decodes start/SGL-DIFF/channel from the controller, fetches a sample from
// an external source and shifts it back MSB first after a null bit.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  adc_spi_responder_if.slave spi,
  output logic [2:0]  req_channel,
  output logic        req_diffn,
  input  logic [9:0]  sample,
  output logic        busy,
  output logic [15:0] conv_count,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    SAMPLE     = 3'd3,  // waiting for the sample-clock rise
    LATCH      = 3'd4,  // waiting for the fall that latches the sample
    DATA       = 3'd5,
    DONE       = 3'd6
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_d;
  logic                   clk_d;
  // Fills with ones after reset; once the top bit is set the synchronizer
  // and edge registers reflect the real pins instead of their reset values.
  logic [SYNC_STAGES:0]   flush;
  // A frame may only start after CS has been seen high on real pin data, so a
  // frame that was in progress across a reset is ignored.
  logic                   armed;

  logic       cs_s, clk_s, mosi_s;
  logic       cs_fall, cs_rise, rise, fall;
  logic       abort;

  logic [3:0] bitcnt;
  logic [2:0] cmd;
  logic [9:0] shreg;
  logic       miso;
  logic [15:0] conv_cnt;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall = armed & cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  assign rise    = clk_s & ~clk_d;
  assign fall    = ~clk_s & clk_d;

  assign spi.adc_miso = miso;
  assign conv_count   = conv_cnt;

  // Pin synchronizers, edge-detect registers and post-reset arming.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= '1;
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      clk_d     <= 1'b0;
      flush     <= '0;
      armed     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.adc_cs};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi.adc_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.adc_mosi};
      cs_d      <= cs_s;
      clk_d     <= clk_s;
      flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
      armed     <= armed | (flush[SYNC_STAGES] & cs_s & cs_d);
    end
  end

  // Frame state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode; CS deassertion overrides any same-cycle SCLK edge.
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       if (cs_fall) state_next = WAIT_START;
        WAIT_START: if (rise && mosi_s) state_next = CMD;
        CMD:        if (rise && bitcnt == 4'd3) state_next = SAMPLE;
        SAMPLE:     if (rise) state_next = LATCH;
        LATCH:      if (fall) state_next = DATA;
        DATA:       if (fall && bitcnt == 4'd9) state_next = DONE;
        DONE:       state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  // State-derived outputs: busy flag and mid-frame abort detection.
  always_comb begin
    busy  = 1'b0;
    abort = 1'b0;
    case (state)
      WAIT_START:        busy = 1'b1;
      CMD, SAMPLE, LATCH, DATA: begin
        busy  = 1'b1;
        abort = cs_rise;
      end
      default: ;
    endcase
  end

  // Command capture, sample shift-out, conversion counter and error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt      <= '0;
      cmd         <= '0;
      shreg       <= '0;
      miso        <= 1'b0;
      req_channel <= '0;
      req_diffn   <= 1'b0;
      conv_cnt    <= '0;
      frame_err   <= 1'b0;
    end else if (cs_rise) begin
      miso <= 1'b0;
      if (abort) frame_err <= 1'b1;
    end else begin
      case (state)
        WAIT_START: if (rise && mosi_s) bitcnt <= '0;
        CMD: if (rise) begin
          cmd    <= {cmd[1:0], mosi_s};
          bitcnt <= bitcnt + 4'd1;
          // cmd now holds {SGL, D2, D1}; D0 arrives on this edge.
          if (bitcnt == 4'd3) begin
            req_diffn   <= cmd[2];
            req_channel <= {cmd[1:0], mosi_s};
          end
        end
        LATCH: if (fall) begin
          shreg  <= sample;
          miso   <= 1'b0;
          bitcnt <= '0;
        end
        DATA: if (fall) begin
          miso   <= shreg[9];
          shreg  <= {shreg[8:0], 1'b0};
          bitcnt <= bitcnt + 4'd1;
          if (bitcnt == 4'd9) conv_cnt <= conv_cnt + 16'd1;
        end
        DONE: if (fall) miso <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: a driver acts as the ADC
// controller and queues the expected frame outcome; a monitor records MISO at
// every SCLK edge and compares the frame against the queued expectation.
module tb_adc_spi_responder;
  localparam int H = 10;  // SCLK half period in system clocks

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req_channel;
  logic        req_diffn;
  logic [9:0]  sample;
  logic        busy;
  logic [15:0] conv_count;
  logic        frame_err;
  logic [9:0]  src_mem [16];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          z;
    int          n;
    logic [9:0]  val;
    bit          ignored;
    logic [15:0] conv;
    bit          err;
    logic [2:0]  ch;
    bit          diffn;
    bit          busy;
  } rec_t;

  rec_t sb [$];

  // Reference state of the responder, updated per frame from the frame rules.
  logic [15:0] m_conv = '0;
  bit          m_err = 1'b0;
  logic [2:0]  m_ch = '0;
  bit          m_diffn = 1'b0;

  adc_spi_responder_if spi_if ();

  always #10 clock = ~clock;

  // Sample source: a combinational lookup indexed by the requested input.
  assign sample = src_mem[{req_diffn, req_channel}];

  adc_spi_responder #(.SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .spi         (spi_if),
    .req_channel (req_channel),
    .req_diffn   (req_diffn),
    .sample      (sample),
    .busy        (busy),
    .conv_count  (conv_count),
    .frame_err   (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // MISO seen just before SCLK rise r (and the fall that follows it) is what
  // the fall of cycle r-1 drove: null on fall z+5, B9..B0 on falls z+6..z+15.
  function automatic logic miso_model(input int z, input logic [9:0] v, input int r);
    int f;
    f = r - 1;
    if (f >= z + 6 && f <= z + 15) return v[9 - (f - z - 6)];
    return 1'b0;
  endfunction

  function automatic logic mosi_bit(input int r, input int z, input bit sgl, input logic [2:0] ch);
    if (r < z)      return 1'b0;
    if (r == z)     return 1'b1;
    if (r == z + 1) return sgl;
    if (r == z + 2) return ch[2];
    if (r == z + 3) return ch[1];
    if (r == z + 4) return ch[0];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive_rises(input int z, input bit sgl, input logic [2:0] ch, input int n);
    for (int r = 0; r < n; r++) begin
      spi_if.adc_mosi = mosi_bit(r, z, sgl, ch);
      wait_clks(2);
      spi_if.adc_clk = 1'b1;
      wait_clks(H);
      spi_if.adc_clk = 1'b0;
      wait_clks(H - 2);
    end
  endtask

  // One frame of n SCLK rises after z leading zeros; fewer than z+17 rises
  // means CS is raised early.
  task automatic run_frame(input int z, input bit sgl, input logic [2:0] ch,
                           input logic [9:0] val, input int n);
    rec_t rc;
    bit complete;
    src_mem[{sgl, ch}] = val;
    complete = (n >= z + 16);
    if (n >= z + 5) begin
      m_ch    = ch;
      m_diffn = sgl;
    end
    if (complete) m_conv = m_conv + 16'd1;
    else if (n >= z + 1) m_err = 1'b1;
    rc.z = z; rc.n = n; rc.val = val; rc.ignored = 1'b0;
    rc.conv = m_conv; rc.err = m_err; rc.ch = m_ch; rc.diffn = m_diffn;
    rc.busy = !complete;
    sb.push_back(rc);
    spi_if.adc_cs = 1'b0;
    wait_clks(12);
    drive_rises(z, sgl, ch, n);
    wait_clks(H);
    spi_if.adc_cs = 1'b1;
    spi_if.adc_mosi = 1'b0;
    wait_clks(14);
  endtask

  // Reset asserted in the middle of the data phase, released with CS low.
  task automatic reset_mid_data();
    rec_t rc;
    src_mem[{1'b1, 3'd3}] = 10'h2DB;
    spi_if.adc_cs = 1'b0;
    wait_clks(12);
    drive_rises(0, 1'b1, 3'd3, 11);
    wait_clks(3);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_async_miso", spi_if.adc_miso, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_conv", conv_count, 16'd0);
    chk("rst_async_err", frame_err, 1'b0);
    chk("rst_async_ch", req_channel, 3'd0);
    chk("rst_async_diffn", req_diffn, 1'b0);
    m_conv = '0; m_err = 1'b0; m_ch = '0; m_diffn = 1'b0;
    rc.z = 0; rc.n = 17; rc.val = '0; rc.ignored = 1'b1;
    rc.conv = m_conv; rc.err = m_err; rc.ch = m_ch; rc.diffn = m_diffn;
    rc.busy = 1'b0;
    sb.push_back(rc);
    wait_clks(5);
    reset_n = 1'b1;
    wait_clks(10);
    drive_rises(0, 1'b0, 3'd6, 17);
    wait_clks(H);
    spi_if.adc_cs = 1'b1;
    spi_if.adc_mosi = 1'b0;
    wait_clks(14);
  endtask

  // Monitor: records MISO at each SCLK edge; scores the frame on CS rise.
  initial begin
    logic cap [$];
    rec_t rc;
    int mism;
    logic e_bit;
    forever begin
      @(posedge spi_if.adc_clk or negedge spi_if.adc_clk or posedge spi_if.adc_cs or negedge reset_n);
      if (!reset_n) begin
        cap.delete();
      end else if (spi_if.adc_cs) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          rc = sb.pop_front();
          chk("edge_count", cap.size(), 2 * rc.n);
          mism = 0;
          foreach (cap[e]) begin
            e_bit = rc.ignored ? 1'b0 : miso_model(rc.z, rc.val, e / 2);
            if (cap[e] !== e_bit) mism++;
          end
          chk("miso_seq_mismatches", mism, 0);
          chk("busy_at_cs_rise", busy, rc.busy);
          cap.delete();
          repeat (5) @(negedge clock);
          chk("miso_after_cs", spi_if.adc_miso, 1'b0);
          chk("busy_after_cs", busy, 1'b0);
          chk("conv_count", conv_count, rc.conv);
          chk("frame_err", frame_err, rc.err);
          chk("req_channel", req_channel, rc.ch);
          chk("req_diffn", req_diffn, rc.diffn);
        end
      end else begin
        cap.push_back(spi_if.adc_miso);
      end
    end
  end

  // Driver: directed frames from the test plan, then randomized frames.
  initial begin
    int z, n;
    for (int i = 0; i < 16; i++) src_mem[i] = '0;
    spi_if.adc_cs = 1'b1;
    spi_if.adc_clk = 1'b0;
    spi_if.adc_mosi = 1'b0;
    #5;
    chk("reset_miso", spi_if.adc_miso, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_conv", conv_count, 16'd0);
    chk("reset_err", frame_err, 1'b0);
    chk("reset_ch", req_channel, 3'd0);
    chk("reset_diffn", req_diffn, 1'b0);
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(10);

    run_frame(0, 1'b1, 3'd5, 10'h2A5, 17);
    run_frame(3, 1'b0, 3'd2, 10'h001, 20);
    run_frame(0, 1'b1, 3'd1, 10'h1E7 | 10'h020, 11);  // CS up after B5 = 1
    run_frame(1, 1'b1, 3'd4, 10'h15A, 18);
    run_frame(0, 1'b1, 3'd7, 10'h3FF, 21);            // four extra SCLKs

    @(negedge clock) force dut.conv_cnt = 16'hFFFF;
    @(negedge clock) release dut.conv_cnt;
    m_conv = 16'hFFFF;
    wait_clks(2);
    run_frame(2, 1'b0, 3'd0, 10'h2C3, 19);            // wraps to 0

    for (int k = 0; k < 18; k++) begin
      z = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) n = $urandom_range(1, z + 15);
      else n = z + 17 + $urandom_range(0, 4);
      run_frame(z, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                10'($urandom), n);
    end

    reset_mid_data();
    run_frame(1, 1'b1, 3'd6, 10'h24D, 18);

    wait_clks(10);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #4ms;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
